// File: rtl/spike_event_logger.sv
// rtl/spike_event_logger.sv - timestamps pre/post spike onsets and streams them out as byte pairs
// Optional drop-marker words are enabled by defining SPIKE_LOG_DROP_MARKER_EN.
module spike_event_logger #(
    parameter int TS_WIDTH   = 14,
    parameter int DEPTH      = 8,
    parameter int DROP_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ena,
    input  logic                     spike_a,
    input  logic                     spike_b,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [DROP_WIDTH-1:0]    drop_count
);
    localparam int AW     = $clog2(DEPTH);
    localparam int WORD_W = 2 + TS_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;

    logic [TS_WIDTH-1:0] ts;
    logic                spike_a_q;
    logic                spike_b_q;
    logic [WORD_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [WORD_W-1:0]   hold;
    logic [1:0]          state;

    logic                onset_a;
    logic                onset_b;
    logic                onset_any;
    logic                fifo_nonempty;
    logic                pop;
    logic                room;
    logic                drop;
    logic                mark;
    logic                wr_en;
    logic [WORD_W-1:0]   wr_word;

    assign onset_a       = spike_a & ~spike_a_q & ena;
    assign onset_b       = spike_b & ~spike_b_q & ena;
    assign onset_any     = onset_a | onset_b;
    assign fifo_nonempty = (fifo_level != '0);

    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = fifo_nonempty;
            S_LO:    pop = out_ready & fifo_nonempty;
            default: pop = 1'b0;
        endcase
    end

    // A full FIFO still accepts a word when the serializer frees a slot on the same edge.
    assign room = (fifo_level < (AW+1)'(DEPTH)) | pop;
    assign drop = onset_any & ~room;

`ifdef SPIKE_LOG_DROP_MARKER_EN
    logic [TS_WIDTH-1:0] pending;

    assign mark    = (pending != '0) & ~onset_any & room;
    assign wr_word = onset_any ? {onset_a, onset_b, ts} : {2'b00, pending};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else if (drop) begin
            if (pending != '1)
                pending <= pending + TS_WIDTH'(1);
        end else if (mark) begin
            pending <= '0;
        end
    end
`else
    assign mark    = 1'b0;
    assign wr_word = {onset_a, onset_b, ts};
`endif

    assign wr_en = (onset_any & room) | mark;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts        <= '0;
            spike_a_q <= 1'b0;
            spike_b_q <= 1'b0;
        end else begin
            spike_a_q <= spike_a;
            spike_b_q <= spike_b;
            if (ena)
                ts <= ts + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_word;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)
                fifo_level <= fifo_level + (AW+1)'(1);
            else if (!wr_en && pop)
                fifo_level <= fifo_level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1)
                drop_count <= drop_count + DROP_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            hold  <= '0;
        end else begin
            if (pop)
                hold <= mem[rd_ptr];
            case (state)
                S_IDLE: if (fifo_nonempty) state <= S_HI;
                S_HI:   if (out_ready) state <= S_LO;
                S_LO:   if (out_ready) state <= fifo_nonempty ? S_HI : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (state == S_HI) || (state == S_LO);

    always_comb begin
        out_data = 8'h00;
        if (state == S_HI)
            out_data = hold[WORD_W-1 -: 8];
        else if (state == S_LO)
            out_data = hold[7:0];
    end

endmodule

// File: tb/tb_spike_event_logger.sv
// tb/tb_spike_event_logger.sv - directed scoreboard bench for spike_event_logger
module tb_spike_event_logger;
    localparam int TSW = 14;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ena;
    logic        spike_a;
    logic        spike_b;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks  = 0;
    int errors  = 0;
    int nevents = 0;
    logic [15:0]    sb[$];
    logic [TSW-1:0] model_ts;

    always #5 clk = ~clk;

    spike_event_logger #(.TS_WIDTH(14), .DEPTH(8), .DROP_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ena        (ena),
        .spike_a    (spike_a),
        .spike_b    (spike_b),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            model_ts <= '0;
        else if (ena)
            model_ts <= model_ts + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ts(input logic [TSW-1:0] v);
        int n = 0;
        while (model_ts != v && n < 20000) begin
            tick();
            n++;
        end
        check("wait_ts", 32'(model_ts), 32'(v));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    // Reassemble byte pairs at the falling edge, ahead of the handshake edge.
    initial begin
        logic       hi_seen;
        logic [7:0] hi_byte;
        logic [15:0] word;
        hi_seen = 1'b0;
        hi_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (!hi_seen) begin
                    hi_byte = out_data;
                    hi_seen = 1'b1;
                end else begin
                    hi_seen = 1'b0;
                    word    = {hi_byte, out_data};
                    nevents++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL sb_underflow: observed word 0x%04h expected none", word);
                    end else begin
                        check("stream_word", 32'(word), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] w;
        int n0;
        reset_n   = 1'b0;
        ena       = 1'b0;
        spike_a   = 1'b0;
        spike_b   = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_fifo_level", 32'(fifo_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_drop_count", 32'(drop_count), 0);
        reset_n = 1'b1;
        ena     = 1'b1;

        // single onset at ts=5 with exact latency
        wait_ts(14'd5);
        spike_a = 1'b1;
        sb.push_back({2'b10, model_ts});
        tick();
        check("lat_k_valid", 32'(out_valid), 0);
        check("lat_k_level", 32'(fifo_level), 1);
        tick();
        check("lat_hi", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h80});
        tick();
        check("lat_lo", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h05});
        tick();
        check("lat_idle", 32'(out_valid), 0);
        spike_a = 1'b0;
        tick();
        wait_drain("drain_single");

        // simultaneous onsets
        wait_ts(14'h0123);
        spike_a = 1'b1;
        spike_b = 1'b1;
        sb.push_back({2'b11, model_ts});
        n0 = nevents;
        repeat (6) tick();
        spike_a = 1'b0;
        spike_b = 1'b0;
        tick();
        wait_drain("drain_simul");
        check("simul_one_event", nevents, n0 + 1);

        // backpressure
        out_ready = 1'b0;
        spike_b   = 1'b1;
        w = {2'b01, model_ts};
        sb.push_back(w);
        tick();
        tick();
        spike_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_stable", {23'd0, out_valid, out_data}, {23'd0, 1'b1, w[15:8]});
            tick();
        end
        out_ready = 1'b1;
        wait_drain("drain_bp");

        // overflow: 9 accepted (8 FIFO + 1 holding), 2 dropped
        out_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            spike_a = 1'b1;
            if (i < 9)
                sb.push_back({2'b10, model_ts});
            tick();
            spike_a = 1'b0;
            tick();
        end
        check("ovf_level", 32'(fifo_level), 8);
        check("ovf_drop_count", 32'(drop_count), 2);
        check("ovf_sticky", 32'(overflow), 1);
`ifdef SPIKE_LOG_DROP_MARKER_EN
        sb.push_back(16'h0002);
`endif
        out_ready = 1'b1;
        wait_drain("drain_ovf");
        check("ovf_level_empty", 32'(fifo_level), 0);

        // timestamp wrap
        wait_ts(14'h3FFF);
        spike_b = 1'b1;
        sb.push_back({2'b01, model_ts});
        tick();
        spike_b = 1'b0;
        tick();
        wait_ts(14'd1);
        spike_b = 1'b1;
        sb.push_back({2'b01, model_ts});
        tick();
        spike_b = 1'b0;
        tick();
        wait_drain("drain_wrap");

        // ena=0: no capture, timestamp frozen
        ena     = 1'b0;
        spike_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ena0_no_event", {27'd0, out_valid, fifo_level}, 0);
        end
        spike_a = 1'b0;
        ena     = 1'b1;
        tick();
        spike_a = 1'b1;
        sb.push_back({2'b10, model_ts});
        tick();
        spike_a = 1'b0;
        tick();
        wait_drain("drain_ena");

`ifdef SPIKE_LOG_DROP_MARKER_EN
        check("total_events", nevents, 16);
`else
        check("total_events", nevents, 15);
`endif
        check("final_drop_count", 32'(drop_count), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_event_logger.md
Name: spike_event_logger

Overview:
- Downstream consumer of the two neuron spike outputs (presynaptic and postsynaptic) of the HH/STDP pair.
- Detects spike onsets and timestamps them against a free-running cycle counter.
- Buffers events in a small FIFO and streams each one out as two bytes over a valid/ready interface.
- Gives the chip an off-chip spike-timing record for checking STDP behaviour.

Parameters:
- TS_WIDTH, 14, timestamp width; event word = 2 + TS_WIDTH = 16 bits.
- DEPTH, 8, FIFO depth in events; power of 2, at least 2.
- DROP_WIDTH, 8, width of the saturating dropped-event counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- ena  in  1  capture enable; also gates the timestamp counter.
- spike_a  in  1  presynaptic neuron spike level.
- spike_b  in  1  postsynaptic neuron spike level.
- out_data  out  8  serial byte output.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer ready.
- fifo_level  out  $clog2(DEPTH)+1  events held in FIFO (excludes the word in the serializer).
- overflow  out  1  sticky: at least one event dropped since reset.
- drop_count  out  DROP_WIDTH  total dropped events, saturating.

Behaviour:
- Reset: asynchronous, active-low; "reset_n low" means asserted, on any edge. All state clears immediately and out_valid drops at once. Reset values:
  - out_valid=0, out_data=0, fifo_level=0, overflow=0, drop_count=0.
  - timestamp=0, spike_a_q=spike_b_q=0, FSM=IDLE.
- Timestamp: TS_WIDTH-bit counter, +1 every cycle while ena=1, held while ena=0. Wraps from 2^TS_WIDTH-1 to 0 with no flag.
- Onset detection: spike_x_q registers spike_x every cycle regardless of ena.
  - An onset on x is spike_x & ~spike_x_q & ena, sampled at edge k.
  - The word captures the timestamp value present before edge k's increment.
- Event word: {onset_a, onset_b, ts}. Simultaneous onsets produce one word with bits[15:14]=11. A level held high produces only one event.
- FIFO write at edge k:
  - Accepted if level<DEPTH, or if the serializer pops at the same edge.
  - Otherwise the word is dropped: drop_count +1 (saturating at 2^DROP_WIDTH-1) and overflow set.
- Serializer FSM:
  - IDLE: out_valid=0. If FIFO non-empty, pop to the holding register and go to HI.
  - HI: out_valid=1, out_data=word[15:8]. On out_valid&out_ready, go to LO.
  - LO: out_valid=1, out_data=word[7:0]. On handshake, if FIFO non-empty pop and go to HI (back-to-back, no idle cycle); else go to IDLE.
- Backpressure: out_data and out_valid stay stable while out_valid=1 and out_ready=0.
- Latency: onset sampled at edge k → written at k → popped at k+1 → out_valid=1 with the high byte after edge k+1, provided the FIFO was empty and the FSM was IDLE.
- Capacity: DEPTH words in FIFO plus 1 in the holding register.
- ena=0: no new captures; the serializer keeps draining.

Optional Feature:
- Macro: SPIKE_LOG_DROP_MARKER_EN.
- Defined:
  - A pending-drop counter (TS_WIDTH bits, saturating) increments alongside drop_count.
  - On any edge where it is non-zero, no onset occurs, and a write would be accepted, insert marker word {2'b00, pending}; pending clears at that edge.
  - drop_count and overflow are unaffected by marker insertion.
- Not defined: no markers are ever emitted and source field 00 never appears.

Test Plan:
- Single onset: reset, ena=1, spike_a rises when ts=5, out_ready=1 → bytes 0x80 then 0x05 on consecutive cycles; out_valid high 2 cycles.
- Simultaneous onsets: spike_a and spike_b rise together at ts=0x0123 → bytes 0xC1, 0x23; only one event emitted.
- Backpressure: one event, out_ready=0 for 10 cycles → out_valid=1 and out_data=high byte stable throughout; release → high then low byte.
- Overflow: out_ready=0, 11 distinct onsets → fifo_level=8, 9 events accepted, drop_count=2, overflow=1. Drain → exactly 9 events in timestamp order.
- Wrap and ena: onsets at ts=16383 and, after the wrap, at ts=1 → words 0x3FFF|src and 0x0001|src. Hold ena=0 for 5 cycles with an onset during it → ts frozen, no event.
- Marker (macro defined): the overflow scenario, then drain with out_ready=1 → marker word 0x0002 appears after the space frees; pending counter returns to 0.
